// File: rtl/puf_challenge_sequencer_pkg.sv
// puf_seq_pkg: FSM state encoding and helpers
// shared by the PUF challenge sequencer files.
package puf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    HOLD,
    CAPTURE,
    NEXT,
    DONE
  } state_e;

  localparam int MAX_RESP_W = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_RESP_W-1:0] maj3(
    input logic [MAX_RESP_W-1:0] a,
    input logic [MAX_RESP_W-1:0] b,
    input logic [MAX_RESP_W-1:0] c
  );
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Sequencer <-> PUF / consumer signal bundle.
// master: sequencer side, slave: PUF stub + consumer side.
interface puf_challenge_sequencer_if
  import puf_seq_pkg::*;
#(
  parameter int CHA_W  = 4,
  parameter int RESP_W = 4,
  parameter int N_CHAL = 256,
  parameter int SIG_W  = 32
);
  localparam int IDX_W = idx_w(N_CHAL);

  logic              start;
  logic              busy;
  logic              done;
  logic [CHA_W-1:0]  cha0;
  logic [CHA_W-1:0]  cha1;
  logic              puf_enable;
  logic [RESP_W-1:0] puf_response;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic [IDX_W-1:0]  resp_index;
  logic [SIG_W-1:0]  signature;

  modport master (
    input  start, puf_response,
    output busy, done, cha0, cha1, puf_enable,
    output resp_valid, resp_data, resp_index,
    output signature
  );

  modport slave (
    output start, puf_response,
    input  busy, done, cha0, cha1, puf_enable,
    input  resp_valid, resp_data, resp_index,
    input  signature
  );

endinterface

// File: rtl/puf_challenge_sequencer_resp_sync.sv
// puf_resp_sync: W-wide 2-flop synchronizer.
// Ports: clock, reset (async high), d_i, q_o.
module puf_resp_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Walks challenges into an RO PUF, captures
// each synchronized response, folds into a signature.
// Ports: clock, reset (async high), bus (master).
// PUF_SEQ_MAJORITY_EN: 3 measurements per
// challenge, reports the bitwise majority.
module puf_challenge_sequencer
  import puf_seq_pkg::*;
#(
  parameter int CHA_W         = 4,
  parameter int RESP_W        = 4,
  parameter int N_CHAL        = 256,
  parameter int EN_CYCLES     = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int SIG_W         = 32
) (
  input logic clock,
  input logic reset,
  puf_challenge_sequencer_if.master bus
);

  localparam int IDX_W = idx_w(N_CHAL);
  localparam int CMAX  =
    (EN_CYCLES > SETTLE_CYCLES) ?
    EN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(CMAX);
  localparam logic [CNT_W-1:0] SET_LD =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD =
    CNT_W'(EN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(N_CHAL - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic              vld_q, vld_d;
  logic [RESP_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic              en_q, en_d;
  logic [RESP_W-1:0] samp;
  logic [RESP_W-1:0] res;
  logic              last;
  logic              emit;
  logic [2*CHA_W-1:0] chal;

`ifdef PUF_SEQ_MAJORITY_EN
  logic [1:0]        rep_q, rep_d;
  logic [RESP_W-1:0] m0_q, m0_d;
  logic [RESP_W-1:0] m1_q, m1_d;
`endif

  puf_resp_sync #(.W(RESP_W)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (bus.puf_response),
    .q_o   (samp)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    ridx_d  = ridx_q;
    last    = (cnt_q == '0);
    emit    = 1'b0;
    res     = samp;
`ifdef PUF_SEQ_MAJORITY_EN
    rep_d   = rep_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    res     = RESP_W'(maj3(
                MAX_RESP_W'(m0_q),
                MAX_RESP_W'(m1_q),
                MAX_RESP_W'(samp)));
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
          cnt_d   = SET_LD;
          idx_d   = '0;
          sig_d   = '0;
        end
      end
      ARM: begin
        if (last) begin
          state_d = MEASURE;
          cnt_d   = EN_LD;
`ifdef PUF_SEQ_MAJORITY_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEASURE: begin
        if (last) begin
          state_d = HOLD;
          cnt_d   = SET_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (last) state_d = CAPTURE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
`ifdef PUF_SEQ_MAJORITY_EN
        if (rep_q == 2'd2) begin
          emit = 1'b1;
        end else begin
          if (rep_q == 2'd0) m0_d = samp;
          else m1_d = samp;
          rep_d   = rep_q + 2'd1;
          state_d = MEASURE;
          cnt_d   = EN_LD;
        end
`else
        emit = 1'b1;
`endif
      end
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ARM;
          cnt_d   = SET_LD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (emit) begin
      state_d = NEXT;
      vld_d   = 1'b1;
      data_d  = res;
      ridx_d  = idx_q;
      sig_d   = {sig_q[SIG_W-RESP_W-1:0],
                 sig_q[SIG_W-1-:RESP_W] ^ res};
    end
    en_d = (state_d == MEASURE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sig_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      ridx_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      ridx_q  <= ridx_d;
      en_q    <= en_d;
    end
  end

`ifdef PUF_SEQ_MAJORITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_q <= '0;
      m0_q  <= '0;
      m1_q  <= '0;
    end else begin
      rep_q <= rep_d;
      m0_q  <= m0_d;
      m1_q  <= m1_d;
    end
  end
`endif

  // idx is only stepped in NEXT (and cleared
  // on start), so the challenge is stable
  // across the whole enable window.
  assign chal = (2*CHA_W)'(idx_q);

  assign bus.cha0       = chal[CHA_W-1:0];
  assign bus.cha1       = chal[2*CHA_W-1:CHA_W];
  assign bus.puf_enable = en_q;
  assign bus.busy       = (state_q != IDLE) &&
                          (state_q != DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.resp_valid = vld_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_index = ridx_q;
  assign bus.signature  = sig_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer with a
// stub PUF and a response scoreboard.
module tb_puf_challenge_sequencer;

  localparam int N   = 4;
  localparam int EN  = 8;
  localparam int SET = 2;
`ifdef PUF_SEQ_MAJORITY_EN
  localparam int NM  = 3;
  localparam int PER = SET + 3*(EN+SET+1) + 1;
`else
  localparam int NM  = 1;
  localparam int PER = 2*SET + EN + 1 + 1;
`endif

  typedef struct packed {
    logic [31:0] idx;
    logic [3:0]  data;
    logic [31:0] k;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  puf_challenge_sequencer_if #(
    .CHA_W(4), .RESP_W(4),
    .N_CHAL(N), .SIG_W(32)
  ) bus ();

  puf_challenge_sequencer #(
    .CHA_W(4), .RESP_W(4), .N_CHAL(N),
    .EN_CYCLES(EN), .SETTLE_CYCLES(SET),
    .SIG_W(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int mode = 0;
  int meas_n = 0;
  int meas_base = 0;
  int total = 0;
  int bad = 0;
  logic [3:0] stub;
  logic [3:0] mtbl [3] = '{4'h5, 4'hF, 4'h5};

  always @(posedge bus.puf_enable)
    meas_n <= meas_n + 1;

  always_comb begin
    stub = 4'hA;
    if (mode == 1) stub = bus.cha1 ^ bus.cha0;
    if (mode == 2)
      stub = mtbl[(meas_n - meas_base + 2) % 3];
  end
  assign bus.puf_response = stub;

  ev_t exp_q[$];
  ev_t got_q[$];
  int done_q[$];
  int en_q[$];
  int viol, cha1_nz;
  logic busy_at;
  logic [31:0] sig_exp;

  function automatic logic [31:0] fold(
    input logic [31:0] s, input logic [3:0] d);
    return {s[27:0], s[31:28] ^ d};
  endfunction

  task automatic expect_run(input int m);
    logic [3:0] d;
    sig_exp = '0;
    for (int i = 0; i < N; i++) begin
      d = (m == 0) ? 4'hA :
          (m == 1) ? 4'(i) : 4'h5;
      exp_q.push_back({32'(i), d, 32'(PER*(i+1))});
      sig_exp = fold(sig_exp, d);
    end
  endtask

  task automatic start_run();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // k counts negedges after the start edge.
  task automatic collect(input int budget,
                         input int start_at);
    int run;
    logic [3:0] pc0, pc1;
    logic pen;
    got_q.delete(); done_q.delete();
    en_q.delete();
    viol = 0; cha1_nz = 0; run = 0;
    busy_at = 1'bx;
    pc0 = bus.cha0; pc1 = bus.cha1;
    pen = bus.puf_enable;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(negedge clock);
      bus.start = 1'b0;
      if (bus.resp_valid)
        got_q.push_back({32'(bus.resp_index),
                         bus.resp_data, 32'(k)});
      if (bus.done) done_q.push_back(k);
      if (bus.puf_enable) run++;
      else if (pen) begin
        en_q.push_back(run);
        run = 0;
      end
      if ((bus.cha0 !== pc0 || bus.cha1 !== pc1)
          && (bus.puf_enable || pen)) viol++;
      if (bus.cha1 !== 4'h0) cha1_nz++;
      if (k == start_at) begin
        busy_at = bus.busy;
        bus.start = 1'b1;
      end
      pc0 = bus.cha0; pc1 = bus.cha1;
      pen = bus.puf_enable;
      if (done_q.size() > 0 && k >= done_q[0] + 2)
        break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [52:0] o;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    o = {bus.busy, bus.done, bus.puf_enable,
         bus.resp_valid, bus.cha0, bus.cha1,
         bus.resp_data, bus.resp_index,
         bus.signature, 5'b0};
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%h exp=0", o);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy got=%b exp=0",
               bus.busy);
    end
  endtask

  task automatic test_fixed();
    ev_t e, g;
    int dk;
    mode = 0;
    exp_q.delete();
    expect_run(0);
    start_run();
    collect(400, -1);
    total++;
    if (got_q.size() != N) begin
      bad++;
      $display("FAIL fix_count got=%0d exp=%0d",
               got_q.size(), N);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL fix_resp got=%h exp=%h", g, e);
      end
    end
    dk = (done_q.size() == 1) ? done_q[0] : -1;
    total++;
    if (dk != PER*N + 1) begin
      bad++;
      $display("FAIL fix_done got=%0d exp=%0d",
               dk, PER*N + 1);
    end
    total++;
    if (bus.signature !== 32'h0000AAAA) begin
      bad++;
      $display("FAIL fix_sig got=%h exp=%h",
               bus.signature, 32'h0000AAAA);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL fix_busy got=%b exp=0",
               bus.busy);
    end
  endtask

  task automatic test_cha_echo();
    ev_t e, g;
    mode = 1;
    exp_q.delete();
    expect_run(1);
    start_run();
    collect(400, -1);
    total++;
    if (got_q.size() != N) begin
      bad++;
      $display("FAIL echo_count got=%0d exp=%0d",
               got_q.size(), N);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL echo_resp got=%h exp=%h",
                 g, e);
      end
    end
    total++;
    if (cha1_nz != 0) begin
      bad++;
      $display("FAIL echo_cha1 got=%0d exp=0",
               cha1_nz);
    end
    total++;
    if (bus.signature !== sig_exp) begin
      bad++;
      $display("FAIL echo_sig got=%h exp=%h",
               bus.signature, sig_exp);
    end
  endtask

  task automatic test_enable();
    int nbad;
    mode = 0;
    start_run();
    collect(400, -1);
    total++;
    if (en_q.size() != N*NM) begin
      bad++;
      $display("FAIL en_pulses got=%0d exp=%0d",
               en_q.size(), N*NM);
    end
    nbad = 0;
    foreach (en_q[i]) if (en_q[i] != EN) nbad++;
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL en_len got=%0d exp=0", nbad);
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL en_cha_chg got=%0d exp=0",
               viol);
    end
  endtask

  task automatic test_start_busy();
    ev_t e, g;
    int dk;
    mode = 0;
    exp_q.delete();
    expect_run(0);
    start_run();
    collect(400, 5);
    total++;
    if (busy_at !== 1'b1) begin
      bad++;
      $display("FAIL sb_busy got=%b exp=1",
               busy_at);
    end
    total++;
    if (got_q.size() != N) begin
      bad++;
      $display("FAIL sb_count got=%0d exp=%0d",
               got_q.size(), N);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL sb_resp got=%h exp=%h", g, e);
      end
    end
    dk = (done_q.size() == 1) ? done_q[0] : -1;
    total++;
    if (dk != PER*N + 1) begin
      bad++;
      $display("FAIL sb_done got=%0d exp=%0d",
               dk, PER*N + 1);
    end
  endtask

  task automatic test_reset_mid();
    ev_t e, g;
    logic [52:0] o;
    mode = 0;
    start_run();
    collect(2*PER + 5, -1);
    total++;
    if (got_q.size() != 2 || !bus.puf_enable
        || bus.cha0 !== 4'h2) begin
      bad++;
      $display("FAIL rm_pos got=%0d/%b/%h exp=2/1/2",
               got_q.size(), bus.puf_enable,
               bus.cha0);
    end
    reset = 1'b1;
    #1;
    o = {bus.busy, bus.done, bus.puf_enable,
         bus.resp_valid, bus.cha0, bus.cha1,
         bus.resp_data, bus.resp_index,
         bus.signature, 5'b0};
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL rm_outs got=%h exp=0", o);
    end
    @(negedge clock);
    reset = 1'b0;
    collect(30, -1);
    total++;
    if (done_q.size() != 0 || got_q.size() != 0)
    begin
      bad++;
      $display("FAIL rm_quiet got=%0d/%0d exp=0/0",
               done_q.size(), got_q.size());
    end
    exp_q.delete();
    expect_run(0);
    start_run();
    collect(400, -1);
    total++;
    if (got_q.size() != N) begin
      bad++;
      $display("FAIL rm_count got=%0d exp=%0d",
               got_q.size(), N);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL rm_resp got=%h exp=%h", g, e);
      end
    end
    total++;
    if (bus.signature !== sig_exp) begin
      bad++;
      $display("FAIL rm_sig got=%h exp=%h",
               bus.signature, sig_exp);
    end
  endtask

`ifdef PUF_SEQ_MAJORITY_EN
  task automatic test_majority();
    ev_t e, g;
    mode = 2;
    meas_base = meas_n;
    exp_q.delete();
    expect_run(2);
    start_run();
    collect(400, -1);
    total++;
    if (got_q.size() != N) begin
      bad++;
      $display("FAIL maj_count got=%0d exp=%0d",
               got_q.size(), N);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL maj_resp got=%h exp=%h",
                 g, e);
      end
      meas_base = meas_base + 3;
    end
    total++;
    if (bus.signature !== sig_exp) begin
      bad++;
      $display("FAIL maj_sig got=%h exp=%h",
               bus.signature, sig_exp);
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_fixed();
    test_cha_echo();
    test_enable();
    test_start_busy();
    test_reset_mid();
`ifdef PUF_SEQ_MAJORITY_EN
    test_majority();
`endif
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
